// File: rtl/sipo_pkg.sv
// Shared types and the bit-shift helper for the serial/parallel converter family.
// The helper works on a fixed maximum-width vector so it can serve any WIDTH up to SIPO_MAX_W.
package sipo_pkg;

  localparam int unsigned SIPO_MAX_W = 64;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } bit_order_e;

  // Bits of cur above 'width' must be zero; the result is masked to 'width' bits.
  function automatic logic [SIPO_MAX_W-1:0] sipo_shift(
    input logic [SIPO_MAX_W-1:0] cur,
    input logic                  din,
    input bit_order_e            order,
    input int unsigned           width
  );
    logic [SIPO_MAX_W-1:0] mask;
    logic [SIPO_MAX_W-1:0] din_ext;
    logic [SIPO_MAX_W-1:0] res;
    mask    = {SIPO_MAX_W{1'b1}} >> (SIPO_MAX_W - width);
    din_ext = {{(SIPO_MAX_W-1){1'b0}}, din};
    if (order == MSB_FIRST) begin
      res = (cur << 1) | din_ext;
    end else begin
      res = (cur >> 1) | (din_ext << (width - 1));
    end
    return res & mask;
  endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// One-entry holding register for completed words, with a sticky overrun flag.
// A word transfers when out_valid && out_ready at posedge; out_data holds while valid and not ready.
module sipo_out_stage
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun
);

  logic accept;
  logic drop;

  assign accept = out_valid && out_ready;
  assign drop   = load && out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load && !drop) begin
      out_data  <= word;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  // A fresh drop outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserialiser: counts bits into WIDTH-bit frames, per-frame bit order,
// frame resync, and a valid/ready output stage with overrun detection.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic             lsb_first,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy
);

  logic [WIDTH-1:0]      shift_reg;
  bit_order_e            mode_q;
  bit_order_e            eff_order;
  logic                  first_bit;
  logic                  last_bit;
  logic [SIPO_MAX_W-1:0] base_ext;
  logic [SIPO_MAX_W-1:0] shifted_ext;
  logic [WIDTH-1:0]      word;

  // A sync cycle restarts the frame, so its bit shifts into an empty register as bit 0.
  always_comb begin
    first_bit = sync || (bit_cnt == '0);
    eff_order = first_bit ? bit_order_e'(lsb_first) : mode_q;
    base_ext  = '0;
    if (!sync) begin
      base_ext[WIDTH-1:0] = shift_reg;
    end
    shifted_ext = sipo_shift(base_ext, serial_in, eff_order, WIDTH);
    word        = shifted_ext[WIDTH-1:0];
    last_bit    = shift_en && !sync && (bit_cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      mode_q    <= MSB_FIRST;
    end else if (shift_en) begin
      if (first_bit) begin
        mode_q <= eff_order;
      end
      if (last_bit) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else begin
        shift_reg <= word;
        bit_cnt   <= sync ? CNT_W'(1) : bit_cnt + CNT_W'(1);
      end
    end else if (sync) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end
  end

  assign busy = (bit_cnt != '0);

  sipo_out_stage #(
    .WIDTH(WIDTH)
  ) u_out_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (last_bit),
    .word     (word),
    .out_ready(out_ready),
    .ovr_clr  (ovr_clr),
    .out_data (out_data),
    .out_valid(out_valid),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser (WIDTH=8): directed frames, a word scoreboard fed at stimulus time
// and drained by a handshake monitor, plus direct checks of flags and counters.
module tb_sipo_deser;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             shift_en = 1'b0;
  logic             serial_in = 1'b0;
  logic             lsb_first = 1'b0;
  logic             sync = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             overrun;
  logic             ovr_clr = 1'b0;
  logic [CNT_W-1:0] bit_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .serial_in(serial_in),
    .lsb_first(lsb_first),
    .sync     (sync),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr),
    .bit_cnt  (bit_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got %0h expected none", out_data);
      end else begin
        logic [WIDTH-1:0] exp_w;
        exp_w = exp_q.pop_front();
        if (out_data !== exp_w) begin
          errors++;
          $display("FAIL word got %0h expected %0h", out_data, exp_w);
        end
      end
    end
  end

  // Drivers: each call takes one clock, starting and ending 1 time unit after posedge.
  task automatic drive_bit(input logic b, input logic lsb, input logic s);
    shift_en  = 1'b1;
    serial_in = b;
    lsb_first = lsb;
    sync      = s;
    @(posedge clk);
    #1;
    shift_en  = 1'b0;
    sync      = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic lsb);
    for (int i = 0; i < WIDTH; i++) begin
      drive_bit(lsb ? w[i] : w[WIDTH-1-i], lsb, 1'b0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] seq;

    // Reset values
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_cnt", bit_cnt, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // 1: MSB-first 1,1,0,0,0,0,0,0 -> C0, valid for exactly one cycle
    out_ready = 1'b1;
    exp_q.push_back(8'hC0);
    send_frame(8'hC0, 1'b0);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 8'hC0);
    check("t1_cnt", bit_cnt, 0);
    idle(1);
    check("t1_valid_drop", out_valid, 0);

    // 2: mode latched on bit 0 (LSB-first), lsb_first toggled to 0 from bit 3 -> 03
    exp_q.push_back(8'h03);
    seq = 8'b1100_0000;
    for (int i = 0; i < WIDTH; i++) begin
      drive_bit(seq[WIDTH-1-i], (i < 3) ? 1'b1 : 1'b0, 1'b0);
    end
    check("t2_data", out_data, 8'h03);
    idle(2);

    // 3: backpressure, second frame dropped, then accept and clear
    out_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0);
    check("t3_valid_a5", out_valid, 1);
    check("t3_no_ovr_yet", overrun, 0);
    send_frame(8'h3C, 1'b0);
    check("t3_data_held", out_data, 8'hA5);
    check("t3_overrun", overrun, 1);
    check("t3_valid_held", out_valid, 1);
    out_ready = 1'b1;
    idle(1);
    check("t3_valid_after_acc", out_valid, 0);
    check("t3_overrun_sticky", overrun, 1);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    check("t3_overrun_clr", overrun, 0);

    // 4: 12 held, 34 completes on the accepting edge -> valid two cycles, no overrun
    out_ready = 1'b0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b0);
    seq = 8'h34;
    for (int i = WIDTH - 1; i >= 1; i--) begin
      drive_bit(seq[i], 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    drive_bit(seq[0], 1'b0, 1'b0);
    check("t4_valid", out_valid, 1);
    check("t4_data", out_data, 8'h34);
    check("t4_no_ovr", overrun, 0);
    idle(1);
    check("t4_valid_drop", out_valid, 0);

    // 5: sync with shift_en after 5 bits -> new frame 81
    seq = 8'b1011_0000;
    for (int i = 0; i < 5; i++) begin
      drive_bit(seq[WIDTH-1-i], 1'b0, 1'b0);
    end
    check("t5_cnt5", bit_cnt, 5);
    check("t5_busy", busy, 1);
    drive_bit(1'b1, 1'b0, 1'b1);
    check("t5_cnt_sync", bit_cnt, 1);
    exp_q.push_back(8'h81);
    seq = 8'b0000_0010;
    for (int i = 0; i < 7; i++) begin
      drive_bit(seq[WIDTH-1-i], 1'b0, 1'b0);
    end
    check("t5_data", out_data, 8'h81);
    check("t5_cnt0", bit_cnt, 0);
    check("t5_busy0", busy, 0);
    idle(1);

    // sync alone clears a partial frame
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0, 1'b0);
    sync = 1'b1;
    idle(1);
    sync = 1'b0;
    check("sync_cnt", bit_cnt, 0);
    check("sync_busy", busy, 0);

    // sync on the completing bit: no word, bit_cnt 1; then new frame 80
    for (int i = 0; i < 7; i++) drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b1);
    check("sync_last_cnt", bit_cnt, 1);
    check("sync_last_valid", out_valid, 0);
    exp_q.push_back(8'h80);
    for (int i = 0; i < 7; i++) drive_bit(1'b0, 1'b0, 1'b0);
    check("sync_last_data", out_data, 8'h80);
    idle(1);

    // 6: async reset mid-frame with a pending word, then clean FF frame
    out_ready = 1'b0;
    send_frame(8'h5A, 1'b0);
    check("t6_pending", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1, 1'b0, 1'b0);
      idle($urandom_range(0, 3));
    end
    check("t6_cnt4", bit_cnt, 4);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_cnt", bit_cnt, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ovr", overrun, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b0);
    check("t6_data", out_data, 8'hFF);
    check("t6_valid", out_valid, 1);
    idle(3);

    check("words_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
